// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive deserializer
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - multi-flop synchronizer with optional rising-edge strobe
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// rtl/i2s_rx_deser.sv - I2S receive deserializer producing one L/R pair per frame
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bclk_in,
  input  logic              lrck_in,
  input  logic              sdata_in,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid
);

  localparam int                CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] MSB_BIT = {1'b1, {(DATA_W-1){1'b0}}};

  logic bclk_rise;
  logic bclk_s;
  logic ws_s;
  logic sd_s;
  logic lrck_rise;
  logic sd_rise;
  logic unused_sync;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_bclk (
    .clk(clk), .rst(rst), .d_i(bclk_in), .q_o(bclk_s), .rise_o(bclk_rise)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_lrck (
    .clk(clk), .rst(rst), .d_i(lrck_in), .q_o(ws_s), .rise_o(lrck_rise)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_sdata (
    .clk(clk), .rst(rst), .d_i(sdata_in), .q_o(sd_s), .rise_o(sd_rise)
  );

  assign unused_sync = bclk_s | lrck_rise | sd_rise;

  state_e            state_q,   state_d;
  logic              ws_prev_q, ws_prev_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DATA_W-1:0] hold_q,    hold_d;
  logic [DATA_W-1:0] left_q,    left_d;
  logic [DATA_W-1:0] right_q,   right_d;
  logic              valid_q,   valid_d;

  logic [DATA_W-1:0] word;
  logic              ws_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ALIGN;
      ws_prev_q <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_prev_q <= ws_prev_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ws_prev_d = ws_prev_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;

    // Bits land at their final position, so short words come out left-justified.
    word = shift_q;
    if ((cnt_q < CNT_MAX) && sd_s) begin
      word = shift_q | (MSB_BIT >> cnt_q);
    end
    ws_edge = (ws_s != ws_prev_q);

    // Word select is tracked even while disabled so re-alignment sees true edges.
    if (bclk_rise) begin
      ws_prev_d = ws_s;
    end

    if (!en) begin
      state_d = ALIGN;
      shift_d = '0;
      cnt_d   = '0;
    end else if (bclk_rise) begin
      if (ws_edge) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = word;
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      case (state_q)
        ALIGN: begin
          if (ws_edge && (ws_s == CH_LEFT)) begin
            state_d = LEFT;
          end
        end
        LEFT: begin
          if (ws_edge) begin
            hold_d  = word;
            state_d = RIGHT;
          end
        end
        RIGHT: begin
          if (ws_edge) begin
            left_d  = hold_q;
            right_d = word;
            valid_d = 1'b1;
            state_d = LEFT;
          end
        end
        default: state_d = ALIGN;
      endcase
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb/tb_i2s_rx_deser.sv - scoreboard bench for the I2S receive deserializer
module tb_i2s_rx_deser;

  localparam int DW = 32;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          en       = 1'b0;
  logic          bclk_in  = 1'b0;
  logic          lrck_in  = 1'b1;
  logic          sdata_in = 1'b0;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_valid;

  int              n_vec = 0;
  int              n_err = 0;
  logic [2*DW-1:0] exp_q[$];
  logic            carry      = 1'b0;
  logic            prev_valid = 1'b0;

  i2s_rx_deser #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bclk_in     (bclk_in),
    .lrck_in     (lrck_in),
    .sdata_in    (sdata_in),
    .left_data   (left_data),
    .right_data  (right_data),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every pulse pops one expected pair pushed by the stimulus.
  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (!rst) begin
      if (prev_valid) check("valid_gap", {{(DW-1){1'b0}}, sample_valid}, '0);
      if (sample_valid) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_pulse observed=%h/%h expected=no_pulse", left_data, right_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("left_data", left_data, e[2*DW-1:DW]);
          check("right_data", right_data, e[DW-1:0]);
        end
      end
    end
    prev_valid = sample_valid;
  end

  // One BCLK period of 160 ns (16 system clocks); data changes while BCLK is low.
  task automatic send_bit(input logic ws, input logic sd, input bit abort);
    bclk_in  = 1'b0;
    lrck_in  = ws;
    sdata_in = sd;
    #40;
    if (abort) begin
      @(posedge clk);
      #1 en = 1'b0;
      @(posedge clk);
      #1 en = 1'b1;
    end
    #40;
    bclk_in = 1'b1;
    #80;
  endtask

  // bits is MSB-justified; the first bit of a slot carries the previous word's LSB.
  task automatic send_slot(input logic ws, input logic [63:0] bits, input int n,
                           input int en_bit, input int abort_bit);
    logic sd;
    for (int i = 0; i < n; i++) begin
      if (i == en_bit) en = 1'b1;
      if (i == 0) sd = carry;
      else        sd = bits[64-i];
      send_bit(ws, sd, i == abort_bit);
    end
    carry = bits[64-n];
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n, input int abort_bit);
    send_slot(1'b0, l, n, -1, abort_bit);
    send_slot(1'b1, r, n, -1, -1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL %s observed=%0d_pending expected=0_pending", tag, exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_left", left_data, '0);
    check("reset_right", right_data, '0);
    check("reset_valid", {{(DW-1){1'b0}}, sample_valid}, '0);
    rst = 1'b0;
    en  = 1'b1;

    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle_left", left_data, '0);
    check("idle_right", right_data, '0);

    // Nominal, short and long slots back to back.
    send_slot(1'b1, 64'h0, 4, -1, -1);
    repeat (2) begin
      exp_q.push_back({32'hA5A5_0001, 32'h1234_5678});
      send_frame({32'hA5A5_0001, 32'h0}, {32'h1234_5678, 32'h0}, 32, -1);
    end
    exp_q.push_back({32'hBEEF_0000, 32'h0F0F_0000});
    send_frame({16'hBEEF, 48'h0}, {16'h0F0F, 48'h0}, 16, -1);
    exp_q.push_back({32'hDEAD_BEEF, 32'hDEAD_BEEF});
    send_frame({32'hDEAD_BEEF, 2'b11, 30'h0}, {32'hDEAD_BEEF, 2'b11, 30'h0}, 34, -1);
    send_slot(1'b0, 64'h0, 4, -1, -1);
    wait_drain("drain_nominal");

    // Enable arrives in the middle of a right word.
    en = 1'b0;
    send_slot(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8, -1, -1);
    send_slot(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 10, -1);
    exp_q.push_back({32'hCAFE_F00D, 32'h0BAD_1DEA});
    send_frame({32'hCAFE_F00D, 32'h0}, {32'h0BAD_1DEA, 32'h0}, 32, -1);

    // One-clock enable drop inside the left word discards the whole frame.
    send_frame({32'h1111_1111, 32'h0}, {32'h2222_2222, 32'h0}, 32, 10);
    @(negedge clk);
    check("abort_hold_left", left_data, 32'hCAFE_F00D);
    check("abort_hold_right", right_data, 32'h0BAD_1DEA);
    exp_q.push_back({32'h1357_9BDF, 32'h2468_ACE0});
    send_frame({32'h1357_9BDF, 32'h0}, {32'h2468_ACE0, 32'h0}, 32, -1);
    send_slot(1'b0, 64'h0, 4, -1, -1);
    wait_drain("drain_resume");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- I2S receive deserializer, the receive-side counterpart of the 32-bit PISO transmit shifter in the DDS audio path.
- Oversamples external BCLK/LRCK/SDATA with the system clock and shifts in MSB-first serial data.
- Presents one left/right parallel sample pair per frame with a single-cycle valid strobe to downstream logic (loopback checker, DDS capture).

Parameters:
- DATA_W, 32, output word width per channel.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (minimum 2).

Ports:
- clk  input  1  system clock; must satisfy f_clk >= 8 x f_bclk.
- rst  input  1  synchronous active-high reset.
- en  input  1  receive enable; low forces the ALIGN state.
- bclk_in  input  1  I2S bit clock, asynchronous to clk.
- lrck_in  input  1  I2S word select: 0 = left, 1 = right.
- sdata_in  input  1  I2S serial data, MSB first.
- left_data  output  DATA_W  last completed left word.
- right_data  output  DATA_W  last completed right word.
- sample_valid  output  1  one-clk pulse when a new L/R pair is on the outputs.

Behaviour:
- Reset (synchronous, active-high): left_data=0, right_data=0, sample_valid=0, state=ALIGN, shift register=0, bit count=0, all synchronizer flops=0.
- Input conditioning:
  - All three inputs pass through SYNC_STAGES flops.
  - bclk_rise is a one-clk strobe when the synchronized BCLK goes 0->1.
  - LRCK and SDATA are sampled only on bclk_rise.
- Word framing, at bclk_rise k:
  - Capture ws_k and sd_k.
  - sd_k belongs to channel ws_(k-1).
  - If ws_k != ws_(k-1), sd_k is the LSB of that channel's word and the word completes on this strobe. This is the standard I2S one-BCLK delay.
- Shift and count:
  - Bits shift in MSB-first while bit count < DATA_W; further bits in the same word are discarded (truncation).
  - Count saturates at DATA_W.
- Short words: a word with N < DATA_W bits is left-justified, with the N received bits in [DATA_W-1 : DATA_W-N] and zeros below.
- Word complete: count and shift register clear on the same strobe, ready for the next word's MSB.
- States:
  - ALIGN -> LEFT on the first ws transition 1->0 while en=1. No output is produced for the partial word before it.
  - LEFT -> RIGHT at left word complete; result latched into a holding register.
  - RIGHT -> LEFT at right word complete. left_data is updated from the holding register, right_data from the new word, and sample_valid is pulsed, all in the clk cycle after that bclk_rise. Both outputs change in that same cycle.
  - Any state -> ALIGN when en=0 (synchronous). The partial word is discarded, outputs hold their last values, and no sample_valid is issued.
- Output hold: left_data and right_data hold between pulses, and sample_valid never asserts on consecutive clks.
- Reset or en drop mid-frame: the next sample_valid requires a fresh 1->0 LRCK edge followed by a complete left word and a complete right word.
- Static BCLK: no strobes occur and the block stays in its current state indefinitely; there is no timeout.

Decomposition:
- Shared package i2s_pkg:
  - state enum {ALIGN, LEFT, RIGHT};
  - DATA_W default constant;
  - I2S channel constants CH_LEFT=0, CH_RIGHT=1.
- Sub-module i2s_sync_edge: SYNC_STAGES synchronizer plus rising-edge strobe, instantiated for bclk_in. lrck_in and sdata_in use the synchronizer only, through a parameter that disables the edge output.

Test Plan:
- Reset and idle: rst held 3 clks, then en=1 with BCLK stopped -> outputs stay 0, sample_valid never asserts.
- Nominal 32-bit slots, f_clk = 16 x f_bclk, L=32'hA5A5_0001, R=32'h1234_5678, two frames -> exactly two sample_valid pulses, each with left_data=A5A50001 and right_data=12345678.
- Short slots, 16 bits per channel with DATA_W=32, L=16'hBEEF, R=16'h0F0F -> left_data=32'hBEEF_0000, right_data=32'h0F0F_0000.
- Long slots, 34 bits per channel with MSBs 32'hDEAD_BEEF followed by 2'b11 -> left_data=right_data=32'hDEADBEEF, extra bits dropped.
- Mid-frame start: enable during a right word -> the partial right word is ignored and the first sample_valid arrives only after the next complete L then R.
- Abort: en=0 (or rst=1) for 1 clk in the middle of a left word with L=32'h1111_1111 -> no pulse for that frame, outputs unchanged, and normal pulses resume after the next 1->0 LRCK edge and a full frame.
